sobel_data_buffer: RTL and testbench

Streaming 3x3 window generator for the Sobel edge-detection pipeline. It accepts one 8-bit grayscale pixel per clock in raster order for a ROWS x COLS frame, keeps the previous two image rows in line buffers, and presents the full 3x3 neighbourhood ending at the newest pixel. It sits between the grayscale converter and the Sobel gradient/magnitude stage.

---
 rtl/sobel_pkg.sv | 5 +
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_data_buffer.sv | 95 +++++++++
 tb/tb_sobel_data_buffer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: pixel width and the window element type.
package sobel_pkg;
  localparam int unsigned PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

// File: rtl/sobel_line_buffer.sv
// Enable-gated delay line: dout is the value pushed DEPTH accepted samples ago.
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/sobel_data_buffer.sv
// Streaming 3x3 window generator: two line buffers feed the top/middle window rows,
// the incoming pixel feeds the bottom row; done_o flags in-frame windows only.
module sobel_data_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned ROWS = 480,
  parameter int unsigned COLS = 640
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_i,
  input  logic [PIXEL_W-1:0] grayscale_i,
  output logic [PIXEL_W-1:0] d0_o,
  output logic [PIXEL_W-1:0] d1_o,
  output logic [PIXEL_W-1:0] d2_o,
  output logic [PIXEL_W-1:0] d3_o,
  output logic [PIXEL_W-1:0] d4_o,
  output logic [PIXEL_W-1:0] d5_o,
  output logic [PIXEL_W-1:0] d6_o,
  output logic [PIXEL_W-1:0] d7_o,
  output logic [PIXEL_W-1:0] d8_o,
  output logic               done_o
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  pixel_t           win [3][3];
  pixel_t           prev1;
  pixel_t           prev2;

  sobel_line_buffer #(.DEPTH(COLS), .WIDTH(PIXEL_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (done_i),
    .din  (grayscale_i),
    .dout (prev1)
  );

  sobel_line_buffer #(.DEPTH(COLS), .WIDTH(PIXEL_W)) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (done_i),
    .din  (prev1),
    .dout (prev2)
  );

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (done_i) begin
      if (col == COL_W'(COLS - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Window shift; valid only when the full neighbourhood lies in the current frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= done_i && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      if (done_i) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= prev2;
        win[1][2] <= prev1;
        win[2][2] <= grayscale_i;
      end
    end
  end

  assign d0_o = win[0][0];
  assign d1_o = win[0][1];
  assign d2_o = win[0][2];
  assign d3_o = win[1][0];
  assign d4_o = win[1][1];
  assign d5_o = win[1][2];
  assign d6_o = win[2][0];
  assign d7_o = win[2][1];
  assign d8_o = win[2][2];

endmodule

// File: tb/tb_sobel_data_buffer.sv
// Bench for sobel_data_buffer: directed test-plan stream plus random traffic against
// a model that indexes the history of accepted pixels.
module tb_sobel_data_buffer;
  localparam int ROWS = 5;
  localparam int COLS = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_i = 1'b0;
  logic [7:0] grayscale_i = 8'd0;
  logic [7:0] d [9];
  logic       done_o;

  int total = 0;
  int bad = 0;
  int hist[$];
  int valid_seen;
  bit exp_done = 1'b0;

  sobel_data_buffer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst         (rst),
    .done_i      (done_i),
    .grayscale_i (grayscale_i),
    .d0_o        (d[0]),
    .d1_o        (d[1]),
    .d2_o        (d[2]),
    .d3_o        (d[3]),
    .d4_o        (d[4]),
    .d5_o        (d[5]),
    .d6_o        (d[6]),
    .d7_o        (d[7]),
    .d8_o        (d[8]),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Window element (i,j) is the pixel accepted (2-i) rows and (2-j) columns before the newest
  function automatic int exp_pix(input int i, input int j);
    int idx;
    idx = hist.size() - 1 - (2 - i) * COLS - (2 - j);
    return (idx < 0) ? 0 : hist[idx];
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 9; k++)
      check_eq($sformatf("%s_d%0d", tag, k), int'(d[k]), exp_pix(k / 3, k % 3));
    check_eq({tag, "_done"}, int'(done_o), int'(exp_done));
  endtask

  task automatic step(input bit v, input int px);
    int k, r, c;
    done_i = v;
    grayscale_i = 8'(px);
    @(posedge clk);
    #1;
    k = hist.size();
    c = k % COLS;
    r = (k / COLS) % ROWS;
    if (v) begin
      hist.push_back(px & 255);
      exp_done = (r >= 2) && (c >= 2);
    end else begin
      exp_done = 1'b0;
    end
    check_all(v ? "acc" : "hold");
    if (done_o) valid_seen++;
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    hist.delete();
    exp_done = 1'b0;
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all({tag, "_held"});
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    step(0, 0);
    step(0, 0);

    // Frame 1: pixel = 1 + 6r + c
    valid_seen = 0;
    for (int p = 1; p <= 30; p++) begin
      step(1, p);
      if (p == 14) check_eq("pre_first_done", int'(done_o), 0);
      if (p == 15) begin
        check_eq("first_d0", int'(d[0]), 1);
        check_eq("first_d4", int'(d[4]), 8);
        check_eq("first_d8", int'(d[8]), 15);
      end
      if (p == 19) check_eq("row_wrap_done", int'(done_o), 0);
      if (p == 21) check_eq("row_resume_d0", int'(d[0]), 7);
      if (p == 30) begin
        check_eq("last_d0", int'(d[0]), 16);
        check_eq("last_d8", int'(d[8]), 30);
      end
    end
    check_eq("frame1_valid", valid_seen, 12);

    // Frame 2 with a 3-cycle stall mid-row
    valid_seen = 0;
    for (int p = 31; p <= 60; p++) begin
      step(1, p);
      if (p == 45) begin
        step(0, 99);
        step(0, 98);
        step(0, 97);
      end
    end
    check_eq("frame2_valid", valid_seen, 12);

    // Abort mid-frame, then random traffic with another abort later
    for (int p = 61; p <= 70; p++) step(1, p);
    async_reset("mid1");
    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset("mid2");
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
